// File: rtl/kcounter_id_scheduler_if.sv
// ============================================================================
// kcounter_id_scheduler_if
// Phase-error / K-counter control and IDCounter pulse bundle for the scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface kcounter_id_scheduler_if #(
  parameter int K_WIDTH    = 4,
  parameter int PEND_WIDTH = 3
);
  logic                  enable;
  logic                  clr;
  logic                  ph_err;
  logic                  dn_up;
  logic [K_WIDTH-1:0]    k_max;
  logic                  inc_in;
  logic                  dec_in;
  logic [PEND_WIDTH-1:0] pend_count;
  logic                  overflow;
  logic                  busy;

  modport master (
    output enable, clr, ph_err, dn_up, k_max,
    input  inc_in, dec_in, pend_count, overflow, busy
  );

  modport slave (
    input  enable, clr, ph_err, dn_up, k_max,
    output inc_in, dec_in, pend_count, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/kcounter_id_scheduler.sv
// ============================================================================
// kcounter_id_scheduler
// DPLL loop-filter K-counter with rate-limited inc/dec pulse issue to IDCounter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kcounter_id_scheduler #(
  parameter int K_WIDTH    = 4,
  parameter int PEND_WIDTH = 3,
  parameter int GAP        = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  kcounter_id_scheduler_if.slave    bus
);

  localparam int c_gap_w = 4;
  localparam logic [c_gap_w-1:0]         c_gap_load = c_gap_w'(GAP - 1);
  localparam logic [c_gap_w-1:0]         c_gap_one  = c_gap_w'(1);
  localparam logic signed [K_WIDTH+1:0]  c_acc_one  = (K_WIDTH+2)'(1);
  localparam logic signed [PEND_WIDTH:0] c_pend_one = (PEND_WIDTH+1)'(1);
  localparam logic signed [PEND_WIDTH:0] c_pend_max = (PEND_WIDTH+1)'(2**(PEND_WIDTH-1) - 1);
  localparam logic signed [PEND_WIDTH:0] c_pend_min = -c_pend_max;

  logic signed [K_WIDTH:0]      r_acc;
  logic signed [PEND_WIDTH-1:0] r_pend;
  logic [c_gap_w-1:0]           r_gap;
  logic                         r_inc;
  logic                         r_dec;
  logic                         r_overflow;

  logic signed [K_WIDTH+1:0]    w_k_eff;
  logic signed [K_WIDTH+1:0]    w_acc_ext;
  logic signed [K_WIDTH+1:0]    w_acc_up;
  logic signed [K_WIDTH+1:0]    w_acc_dn;
  logic                         w_event;
  logic                         w_carry;
  logic                         w_borrow;
  logic signed [K_WIDTH:0]      w_acc_next;
  logic                         w_issue_inc;
  logic                         w_issue_dec;
  logic signed [PEND_WIDTH:0]   w_pend_ext;
  logic signed [PEND_WIDTH:0]   w_pend_mid;
  logic signed [PEND_WIDTH:0]   w_pend_next;
  logic                         w_drop;
  logic [c_gap_w-1:0]           w_gap_next;

  // Compares run one bit wider than the accumulator so acc+/-1 never wraps.
  assign w_k_eff   = (bus.k_max == '0) ? c_acc_one : $signed({2'b00, bus.k_max});
  assign w_acc_ext = {r_acc[K_WIDTH], r_acc};
  assign w_acc_up  = w_acc_ext + c_acc_one;
  assign w_acc_dn  = w_acc_ext - c_acc_one;
  assign w_event   = bus.enable & bus.ph_err;
  assign w_carry   = w_event & ~bus.dn_up & (w_acc_up >= w_k_eff);
  assign w_borrow  = w_event &  bus.dn_up & (w_acc_dn <= -w_k_eff);

  always_comb begin
    w_acc_next = r_acc;
    if (w_carry || w_borrow) begin
      w_acc_next = '0;
    end else if (w_event) begin
      w_acc_next = bus.dn_up ? w_acc_dn[K_WIDTH:0] : w_acc_up[K_WIDTH:0];
    end
  end

  assign w_issue_inc = (r_gap == '0) && !r_pend[PEND_WIDTH-1] && (r_pend != '0);
  assign w_issue_dec = (r_gap == '0) &&  r_pend[PEND_WIDTH-1];
  assign w_pend_ext  = {r_pend[PEND_WIDTH-1], r_pend};

  // Saturation is judged after this edge's issue, so a carry at +max with an
  // inc going out is still absorbed.
  always_comb begin
    w_pend_mid = w_pend_ext;
    if (w_issue_inc) begin
      w_pend_mid = w_pend_ext - c_pend_one;
    end else if (w_issue_dec) begin
      w_pend_mid = w_pend_ext + c_pend_one;
    end
    w_pend_next = w_pend_mid;
    w_drop      = 1'b0;
    if (w_carry) begin
      if (w_pend_mid == c_pend_max) begin
        w_drop = 1'b1;
      end else begin
        w_pend_next = w_pend_mid + c_pend_one;
      end
    end else if (w_borrow) begin
      if (w_pend_mid == c_pend_min) begin
        w_drop = 1'b1;
      end else begin
        w_pend_next = w_pend_mid - c_pend_one;
      end
    end
  end

  always_comb begin
    w_gap_next = r_gap;
    if (w_issue_inc || w_issue_dec) begin
      w_gap_next = c_gap_load;
    end else if (r_gap != '0) begin
      w_gap_next = r_gap - c_gap_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_pend     <= '0;
      r_gap      <= '0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.clr) begin
      r_acc      <= '0;
      r_pend     <= '0;
      r_gap      <= '0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_acc      <= w_acc_next;
      r_pend     <= w_pend_next[PEND_WIDTH-1:0];
      r_gap      <= w_gap_next;
      r_inc      <= w_issue_inc;
      r_dec      <= w_issue_dec;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign bus.inc_in     = r_inc;
  assign bus.dec_in     = r_dec;
  assign bus.pend_count = r_pend;
  assign bus.overflow   = r_overflow;
  assign bus.busy       = (r_pend != '0) || (r_gap != '0);

endmodule

`default_nettype wire
